// File: rtl/ext_io_bridge.sv
// rtl/ext_io_bridge.sv - CPU external I/O request to registered device-cycle bridge
// Optional device timeout (TIMEOUT_CYCLES) is built in when EXT_IO_TIMEOUT_EN is defined.
module ext_io_bridge #(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int PC_SZ          = 32,
   parameter int RSZ            = 32
) (
   input  logic             clk_in,
   input  logic             reset_in,
   input  logic             io_req,
   input  logic             io_rd,
   input  logic             io_wr,
   input  logic [PC_SZ-1:0] io_addr,
   input  logic [RSZ-1:0]   io_wr_data,
   output logic [RSZ-1:0]   io_rd_data,
   output logic             io_ack,
   output logic             io_ack_fault,
   output logic             dev_sel,
   output logic             dev_we,
   output logic [PC_SZ-1:0] dev_addr,
   output logic [RSZ-1:0]   dev_wdata,
   input  logic [RSZ-1:0]   dev_rdata,
   input  logic             dev_ready,
   input  logic             dev_err
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES out of range 2..65535");
   end

   logic [1:0]       state, state_nxt;
   logic             abandon, abandon_nxt, abandon_now;
   logic             req_ok, tmo_hit, done;
   logic             sel_nxt, we_nxt, ack_nxt, fault_nxt;
   logic [PC_SZ-1:0] addr_nxt;
   logic [RSZ-1:0]   wdata_nxt, rdata_nxt;

   assign req_ok      = (io_rd ^ io_wr) && (io_addr[1:0] == 2'b00);
   assign abandon_now = abandon || !io_req;
   assign done        = (state == BUSY) && (dev_ready || tmo_hit);

`ifdef EXT_IO_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] cnt, cnt_nxt;

   // dev_ready has priority: a timeout only fires on a cycle the device is not ready
   assign tmo_hit = (state == BUSY) && !dev_ready && (cnt == TMO_LAST);

   always_comb begin
      cnt_nxt = cnt;
      if (state == IDLE)
         cnt_nxt = '0;
      else if (state == BUSY && !dev_ready && cnt != 16'hFFFF)
         cnt_nxt = cnt + 16'd1;
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) cnt <= '0;
      else          cnt <= cnt_nxt;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = !io_req ? IDLE : (req_ok ? BUSY : RESP);
         BUSY:    state_nxt = !done ? BUSY : (abandon_now ? IDLE : RESP);
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of the registered outputs; CPU response is zero unless entering RESP
   always_comb begin
      sel_nxt     = dev_sel;
      we_nxt      = dev_we;
      addr_nxt    = dev_addr;
      wdata_nxt   = dev_wdata;
      ack_nxt     = 1'b0;
      fault_nxt   = 1'b0;
      rdata_nxt   = '0;
      abandon_nxt = abandon;
      case (state)
         IDLE: begin
            abandon_nxt = 1'b0;
            if (io_req && req_ok) begin
               sel_nxt   = 1'b1;
               we_nxt    = io_wr;
               addr_nxt  = io_addr;
               wdata_nxt = io_wr_data;
            end else if (io_req) begin
               ack_nxt   = 1'b1;
               fault_nxt = 1'b1;
            end
         end
         BUSY: begin
            abandon_nxt = abandon_now;
            if (dev_ready) begin
               sel_nxt   = 1'b0;
               ack_nxt   = !abandon_now;
               fault_nxt = !abandon_now && dev_err;
               if (!abandon_now && !dev_we && !dev_err)
                  rdata_nxt = dev_rdata;
            end else if (tmo_hit) begin
               sel_nxt   = 1'b0;
               ack_nxt   = !abandon_now;
               fault_nxt = !abandon_now;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         dev_sel      <= 1'b0;
         dev_we       <= 1'b0;
         dev_addr     <= '0;
         dev_wdata    <= '0;
         io_ack       <= 1'b0;
         io_ack_fault <= 1'b0;
         io_rd_data   <= '0;
         abandon      <= 1'b0;
      end else begin
         dev_sel      <= sel_nxt;
         dev_we       <= we_nxt;
         dev_addr     <= addr_nxt;
         dev_wdata    <= wdata_nxt;
         io_ack       <= ack_nxt;
         io_ack_fault <= fault_nxt;
         io_rd_data   <= rdata_nxt;
         abandon      <= abandon_nxt;
      end
   end

endmodule

// File: tb/tb_ext_io_bridge.sv
// tb/tb_ext_io_bridge.sv - directed self-checking bench for ext_io_bridge
// Timeout scenario follows EXT_IO_TIMEOUT_EN (TIMEOUT_CYCLES=8 when defined).
module tb_ext_io_bridge;
   logic        clk_in = 1'b0;
   logic        reset_in = 1'b1;
   logic        io_req = 1'b0, io_rd = 1'b0, io_wr = 1'b0;
   logic [31:0] io_addr = '0, io_wr_data = '0, dev_rdata = '0;
   logic        dev_ready = 1'b0, dev_err = 1'b0;
   logic [31:0] io_rd_data, dev_addr, dev_wdata;
   logic        io_ack, io_ack_fault, dev_sel, dev_we;
   int          n_cmp = 0, n_bad = 0;

   always #5 clk_in = ~clk_in;

`ifdef EXT_IO_TIMEOUT_EN
   ext_io_bridge #(.TIMEOUT_CYCLES(8), .PC_SZ(32), .RSZ(32)) dut (
`else
   ext_io_bridge #(.PC_SZ(32), .RSZ(32)) dut (
`endif
      .clk_in(clk_in), .reset_in(reset_in),
      .io_req(io_req), .io_rd(io_rd), .io_wr(io_wr),
      .io_addr(io_addr), .io_wr_data(io_wr_data),
      .io_rd_data(io_rd_data), .io_ack(io_ack), .io_ack_fault(io_ack_fault),
      .dev_sel(dev_sel), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
      .dev_rdata(dev_rdata), .dev_ready(dev_ready), .dev_err(dev_err));

   task automatic step;
      @(posedge clk_in);
      @(negedge clk_in);
   endtask

   task automatic issue(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
      io_req = 1'b1; io_rd = rd; io_wr = wr; io_addr = addr; io_wr_data = data;
   endtask

   task automatic release_all;
      io_req = 1'b0; io_rd = 1'b0; io_wr = 1'b0; dev_ready = 1'b0; dev_err = 1'b0; dev_rdata = '0;
   endtask

   task automatic test_reset;
      #12;
      n_cmp++; if ({dev_sel, dev_we, io_ack, io_ack_fault} !== 4'b0000) begin n_bad++; $display("FAIL reset_ctl: got %b want 0000", {dev_sel, dev_we, io_ack, io_ack_fault}); end
      n_cmp++; if ({io_rd_data, dev_addr, dev_wdata} !== 96'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", {io_rd_data, dev_addr, dev_wdata}); end
      @(negedge clk_in);
      reset_in = 1'b0;
      step;
   endtask

   task automatic test_read;
      issue(1'b1, 1'b0, 32'h1000_0000, 32'h0);
      step;
      n_cmp++; if ({dev_sel, dev_we, io_ack} !== 3'b100) begin n_bad++; $display("FAIL rd_busy: got %b want 100", {dev_sel, dev_we, io_ack}); end
      n_cmp++; if (dev_addr !== 32'h1000_0000) begin n_bad++; $display("FAIL rd_addr: got %h want 10000000", dev_addr); end
      dev_ready = 1'b1; dev_rdata = 32'hDEAD_BEEF;
      step;
      n_cmp++; if ({io_ack, io_ack_fault, dev_sel} !== 3'b100) begin n_bad++; $display("FAIL rd_ack: got %b want 100", {io_ack, io_ack_fault, dev_sel}); end
      n_cmp++; if (io_rd_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_data: got %h want deadbeef", io_rd_data); end
      release_all;
      step;
      n_cmp++; if ({io_ack, io_rd_data} !== 33'd0) begin n_bad++; $display("FAIL rd_after: got %h want 0", {io_ack, io_rd_data}); end
   endtask

   task automatic test_write;
      issue(1'b0, 1'b1, 32'h1000_0004, 32'h1234_5678);
      step;
      io_wr_data = 32'hFFFF_0000; io_addr = 32'h2000_0000;
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if ({dev_sel, dev_we, io_ack, dev_wdata, dev_addr} !== {3'b110, 32'h1234_5678, 32'h1000_0004}) begin
            n_bad++; $display("FAIL wr_hold[%0d]: got %b %h %h want 110 12345678 10000004", i, {dev_sel, dev_we, io_ack}, dev_wdata, dev_addr);
         end
         step;
      end
      dev_ready = 1'b1; dev_rdata = 32'hCAFE_F00D;
      step;
      n_cmp++; if ({io_ack, io_ack_fault, dev_sel} !== 3'b100) begin n_bad++; $display("FAIL wr_ack: got %b want 100", {io_ack, io_ack_fault, dev_sel}); end
      n_cmp++; if (io_rd_data !== 32'h0) begin n_bad++; $display("FAIL wr_rdata: got %h want 0", io_rd_data); end
      release_all;
      step;
      n_cmp++; if (io_ack !== 1'b0) begin n_bad++; $display("FAIL wr_single_ack: got %b want 0", io_ack); end
   endtask

   task automatic test_dev_err;
      issue(1'b1, 1'b0, 32'h1000_0008, 32'h0);
      step;
      dev_ready = 1'b1; dev_err = 1'b1; dev_rdata = 32'hDEAD_BEEF;
      step;
      n_cmp++; if ({io_ack, io_ack_fault} !== 2'b11) begin n_bad++; $display("FAIL err_ack: got %b want 11", {io_ack, io_ack_fault}); end
      n_cmp++; if (io_rd_data !== 32'h0) begin n_bad++; $display("FAIL err_rdata: got %h want 0", io_rd_data); end
      release_all;
      step;
      n_cmp++; if ({io_ack, io_ack_fault} !== 2'b00) begin n_bad++; $display("FAIL err_after: got %b want 00", {io_ack, io_ack_fault}); end
   endtask

   task automatic test_bad_req;
      logic [33:0] vec [3];
      vec[0] = {2'b10, 32'h1000_0002};
      vec[1] = {2'b11, 32'h1000_0000};
      vec[2] = {2'b00, 32'h1000_0000};
      for (int i = 0; i < 3; i++) begin
         issue(vec[i][33], vec[i][32], vec[i][31:0], 32'hAAAA_5555);
         dev_rdata = 32'h7777_7777;
         step;
         n_cmp++; if ({dev_sel, io_ack, io_ack_fault} !== 3'b011) begin n_bad++; $display("FAIL bad_req[%0d]: got %b want 011", i, {dev_sel, io_ack, io_ack_fault}); end
         n_cmp++; if (io_rd_data !== 32'h0) begin n_bad++; $display("FAIL bad_rdata[%0d]: got %h want 0", i, io_rd_data); end
         release_all;
         step;
         n_cmp++; if ({dev_sel, io_ack} !== 2'b00) begin n_bad++; $display("FAIL bad_after[%0d]: got %b want 00", i, {dev_sel, io_ack}); end
      end
   endtask

   task automatic test_timeout;
      int n = 0;
      issue(1'b1, 1'b0, 32'h1000_0020, 32'h0);
      step;
`ifdef EXT_IO_TIMEOUT_EN
      while (dev_sel === 1'b1 && n < 50) begin n++; step; end
      n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL tmo_cycles: got %0d want 8", n); end
      n_cmp++; if ({io_ack, io_ack_fault, io_rd_data} !== {2'b11, 32'h0}) begin n_bad++; $display("FAIL tmo_ack: got %b %h want 11 0", {io_ack, io_ack_fault}, io_rd_data); end
      release_all;
      step;
      n_cmp++; if (io_ack !== 1'b0) begin n_bad++; $display("FAIL tmo_after: got %b want 0", io_ack); end
`else
      for (int i = 0; i < 1000; i++) begin
         if (io_ack === 1'b1) n++;
         step;
      end
      n_cmp++; if (n !== 0) begin n_bad++; $display("FAIL notmo_acks: got %0d want 0", n); end
      n_cmp++; if (dev_sel !== 1'b1) begin n_bad++; $display("FAIL notmo_sel: got %b want 1", dev_sel); end
      release_all;
      reset_in = 1'b1;
      step;
      reset_in = 1'b0;
      step;
`endif
   endtask

   task automatic test_abandon;
      int acks = 0;
      issue(1'b1, 1'b0, 32'h1000_000C, 32'h0);
      step;
      io_req = 1'b0;
      step;
      step;
      dev_ready = 1'b1; dev_rdata = 32'h1111_1111;
      step;
      n_cmp++; if ({dev_sel, io_ack} !== 2'b00) begin n_bad++; $display("FAIL abn_done: got %b want 00", {dev_sel, io_ack}); end
      release_all;
      for (int i = 0; i < 3; i++) begin
         if (io_ack === 1'b1) acks++;
         step;
      end
      n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL abn_acks: got %0d want 0", acks); end
      issue(1'b1, 1'b0, 32'h1000_0010, 32'h0);
      step;
      dev_ready = 1'b1; dev_rdata = 32'h5A5A_5A5A;
      step;
      n_cmp++; if ({io_ack, io_rd_data} !== {1'b1, 32'h5A5A_5A5A}) begin n_bad++; $display("FAIL abn_next: got %b %h want 1 5a5a5a5a", io_ack, io_rd_data); end
      release_all;
      step;
   endtask

   task automatic test_reset_busy;
      int acks = 0;
      issue(1'b1, 1'b0, 32'h1000_0018, 32'h0);
      step;
      n_cmp++; if (dev_sel !== 1'b1) begin n_bad++; $display("FAIL rst_pre: got %b want 1", dev_sel); end
      #2 reset_in = 1'b1;
      #1;
      n_cmp++; if ({dev_sel, io_ack} !== 2'b00) begin n_bad++; $display("FAIL rst_async: got %b want 00", {dev_sel, io_ack}); end
      io_req = 1'b0; dev_ready = 1'b1; dev_rdata = 32'h9999_9999;
      @(negedge clk_in);
      if (io_ack === 1'b1) acks++;
      reset_in = 1'b0;
      dev_ready = 1'b0;
      issue(1'b1, 1'b0, 32'h1000_0014, 32'h0);
      step;
      if (io_ack === 1'b1) acks++;
      n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL rst_no_ack: got %0d want 0", acks); end
      n_cmp++; if ({dev_sel, dev_addr} !== {1'b1, 32'h1000_0014}) begin n_bad++; $display("FAIL rst_first_req: got %b %h want 1 10000014", dev_sel, dev_addr); end
      dev_ready = 1'b1; dev_rdata = 32'h0BAD_F00D;
      step;
      n_cmp++; if ({io_ack, io_rd_data} !== {1'b1, 32'h0BAD_F00D}) begin n_bad++; $display("FAIL rst_first_ack: got %b %h want 1 0badf00d", io_ack, io_rd_data); end
      release_all;
      step;
   endtask

   task automatic test_back_to_back;
      issue(1'b1, 1'b0, 32'h1000_0100, 32'h0);
      step;
      dev_ready = 1'b1; dev_rdata = 32'h0000_00A1;
      step;
      n_cmp++; if ({io_ack, io_rd_data} !== {1'b1, 32'h0000_00A1}) begin n_bad++; $display("FAIL b2b_ack1: got %b %h want 1 000000a1", io_ack, io_rd_data); end
      dev_ready = 1'b0; io_addr = 32'h1000_0200;
      step;
      n_cmp++; if ({dev_sel, io_ack} !== 2'b00) begin n_bad++; $display("FAIL b2b_gap: got %b want 00", {dev_sel, io_ack}); end
      step;
      n_cmp++; if ({dev_sel, dev_addr} !== {1'b1, 32'h1000_0200}) begin n_bad++; $display("FAIL b2b_accept2: got %b %h want 1 10000200", dev_sel, dev_addr); end
      dev_ready = 1'b1; dev_rdata = 32'h0000_00B2;
      step;
      n_cmp++; if ({io_ack, io_rd_data} !== {1'b1, 32'h0000_00B2}) begin n_bad++; $display("FAIL b2b_ack2: got %b %h want 1 000000b2", io_ack, io_rd_data); end
      release_all;
      step;
   endtask

   initial begin
      test_reset;
      test_read;
      test_write;
      test_dev_err;
      test_bad_req;
      test_timeout;
      test_abandon;
      test_reset_busy;
      test_back_to_back;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
